axil_wr_master: RTL and testbench

Converts the registered addr/data valid-ready stream from the write skid buffer into AXI4-Lite write transactions (AW, W, B channels). Sits directly downstream of the skid buffer and drives the AXI4-Lite slave port of the peripheral fabric. AW and W are issued independently. Outstanding writes are tracked up to a fixed limit, and B responses are monitored for errors.

---
 rtl/axil_pkg.sv | 23 ++
 rtl/sat_counter.sv | 41 ++++
 rtl/axil_wr_master.sv | 134 +++++++++++++
 tb/tb_axil_wr_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axil_pkg
// Purpose : Shared AXI4-Lite types and constants for the write and read masters.
// Rev     : 1.0
// ============================================================================
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at all-ones; an increment beats a clear.
// Rev     : 1.0
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);
  import axil_pkg::*;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/axil_wr_master.sv
`default_nettype none
// ============================================================================
// Module  : axil_wr_master
// Purpose : Turns an addr/data valid-ready stream into AXI4-Lite AW/W/B traffic.
// Rev     : 1.0
// ============================================================================
module axil_wr_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_valid_i,
  output logic                                   s_ready_o,
  input  logic [ADDR_WIDTH-1:0]                  s_addr_i,
  input  logic [DATA_WIDTH-1:0]                  s_data_i,
  output logic                                   m_awvalid_o,
  input  logic                                   m_awready_i,
  output logic [ADDR_WIDTH-1:0]                  m_awaddr_o,
  output logic [2:0]                             m_awprot_o,
  output logic                                   m_wvalid_o,
  input  logic                                   m_wready_i,
  output logic [DATA_WIDTH-1:0]                  m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                m_wstrb_o,
  input  logic                                   m_bvalid_i,
  output logic                                   m_bready_o,
  input  logic [1:0]                             m_bresp_i,
  input  logic                                   err_clr_i,
  output logic                                   err_o,
  output logic [ERR_CNT_WIDTH-1:0]               err_cnt_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   out_cnt_o,
  output logic                                   idle_o
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
  logic                  err_q,     err_d;

  logic s_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic b_err;

  // Ready looks only at the downstream readies and the credit count, never s_valid_i.
  assign s_ready_o = (!awvalid_q || m_awready_i) && (!wvalid_q || m_wready_i) &&
                     (out_cnt_q != CNT_MAX);
  assign s_hs      = s_valid_i && s_ready_o;
  assign aw_hs     = awvalid_q && m_awready_i;
  assign w_hs      = wvalid_q && m_wready_i;
  assign b_hs      = m_bvalid_i && m_bready_o;
  assign b_err     = b_hs && resp_is_err(m_bresp_i);

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;

    if (aw_hs) awvalid_d = 1'b0;
    if (w_hs)  wvalid_d  = 1'b0;
    if (s_hs) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = s_addr_i;
      wdata_d   = s_data_i;
    end

    if (s_hs && !b_hs) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (b_hs && !s_hs) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end

    if (b_err) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (b_err),
    .clr_i (err_clr_i),
    .cnt_o (err_cnt_o)
  );

  assign m_awvalid_o = awvalid_q;
  assign m_awaddr_o  = awaddr_q;
  assign m_awprot_o  = AXIL_PROT_DEFAULT;
  assign m_wvalid_o  = wvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = '1;
  assign m_bready_o  = (out_cnt_q != '0);
  assign err_o       = err_q;
  assign out_cnt_o   = out_cnt_q;
  assign idle_o      = (out_cnt_q == '0) && !awvalid_q && !wvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_wr_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_axil_wr_master
// Purpose : Directed and random checks of axil_wr_master against a queue model.
// Rev     : 1.0
// ============================================================================
module tb_axil_wr_master;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_data;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        err_clr;
  logic        err;
  logic [7:0]  err_cnt;
  logic [2:0]  out_cnt;
  logic        idle;

  logic        s_ready2, awvalid2, wvalid2, bready2, err2, idle2;
  logic [31:0] awaddr2, wdata2;
  logic [2:0]  awprot2, out_cnt2;
  logic [3:0]  wstrb2;
  logic [1:0]  err_cnt2;

  always #5 clk = ~clk;

  axil_wr_master #(.MAX_OUTSTANDING(MAXO), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_addr_i(s_addr), .s_data_i(s_data),
    .m_awvalid_o(awvalid), .m_awready_i(awready), .m_awaddr_o(awaddr), .m_awprot_o(awprot),
    .m_wvalid_o(wvalid), .m_wready_i(wready), .m_wdata_o(wdata), .m_wstrb_o(wstrb),
    .m_bvalid_i(bvalid), .m_bready_o(bready), .m_bresp_i(bresp),
    .err_clr_i(err_clr), .err_o(err), .err_cnt_o(err_cnt), .out_cnt_o(out_cnt), .idle_o(idle)
  );

  // Narrow error counter twin sharing every input, to exercise saturation.
  axil_wr_master #(.MAX_OUTSTANDING(MAXO), .ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid_i(s_valid), .s_ready_o(s_ready2),
    .s_addr_i(s_addr), .s_data_i(s_data),
    .m_awvalid_o(awvalid2), .m_awready_i(awready), .m_awaddr_o(awaddr2), .m_awprot_o(awprot2),
    .m_wvalid_o(wvalid2), .m_wready_i(wready), .m_wdata_o(wdata2), .m_wstrb_o(wstrb2),
    .m_bvalid_i(bvalid), .m_bready_o(bready2), .m_bresp_i(bresp),
    .err_clr_i(err_clr), .err_o(err2), .err_cnt_o(err_cnt2), .out_cnt_o(out_cnt2), .idle_o(idle2)
  );

  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  int          m_out;
  bit          m_err;
  int          m_ecnt;
  int          m_ecnt2;
  bit          last_acc;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aw_q.delete();
    w_q.delete();
    m_out   = 0;
    m_err   = 1'b0;
    m_ecnt  = 0;
    m_ecnt2 = 0;
  endtask

  // One clock: compare all outputs against the model, then advance the model.
  task automatic step();
    bit aw_pend, w_pend, exp_rdy, b_hs, b_err;
    @(negedge clk);
    aw_pend = aw_q.size() != 0;
    w_pend  = w_q.size() != 0;
    exp_rdy = (!aw_pend || awready) && (!w_pend || wready) && (m_out != MAXO);
    chk("s_ready",  64'(s_ready),  64'(exp_rdy));
    chk("awvalid",  64'(awvalid),  64'(aw_pend));
    chk("wvalid",   64'(wvalid),   64'(w_pend));
    chk("bready",   64'(bready),   64'(m_out != 0));
    chk("out_cnt",  64'(out_cnt),  64'(m_out));
    chk("err",      64'(err),      64'(m_err));
    chk("err_cnt",  64'(err_cnt),  64'(m_ecnt));
    chk("err_cnt2", 64'(err_cnt2), 64'(m_ecnt2));
    chk("idle",     64'(idle),     64'(m_out == 0 && !aw_pend && !w_pend));
    if (aw_pend) chk("awaddr", 64'(awaddr), 64'(aw_q[0]));
    if (w_pend)  chk("wdata",  64'(wdata),  64'(w_q[0]));

    if (aw_pend && awready) void'(aw_q.pop_front());
    if (w_pend && wready)   void'(w_q.pop_front());
    b_hs     = bvalid && (m_out != 0);
    b_err    = b_hs && (bresp != 2'b00);
    last_acc = s_valid && exp_rdy;
    if (last_acc) begin
      aw_q.push_back(s_addr);
      w_q.push_back(s_data);
    end
    m_out = m_out + int'(last_acc) - int'(b_hs);
    if (b_err) begin
      m_err   = 1'b1;
      m_ecnt  = err_clr ? 1 : ((m_ecnt  < 255) ? m_ecnt  + 1 : 255);
      m_ecnt2 = err_clr ? 1 : ((m_ecnt2 < 3)   ? m_ecnt2 + 1 : 3);
    end else if (err_clr) begin
      m_err   = 1'b0;
      m_ecnt  = 0;
      m_ecnt2 = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_resp(input logic [31:0] a, input logic [1:0] r, input bit clr);
    awready = 1'b1; wready = 1'b1;
    s_valid = 1'b1; s_addr = a; s_data = ~a;
    step();
    s_valid = 1'b0;
    step();
    bvalid = 1'b1; bresp = r; err_clr = clr;
    step();
    bvalid = 1'b0; bresp = 2'b00; err_clr = 1'b0;
  endtask

  task automatic drain();
    int budget;
    s_valid = 1'b0; awready = 1'b1; wready = 1'b1; err_clr = 1'b0; bresp = 2'b00;
    budget = 40;
    while ((m_out != 0 || aw_q.size() != 0 || w_q.size() != 0) && budget > 0) begin
      bvalid = (m_out != 0);
      step();
      budget--;
    end
    bvalid = 1'b0;
    step();
    chk("drain_idle", 64'(idle), 64'(1));
  endtask

  initial begin
    int n;
    vectors = 0; miscompares = 0;
    rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("rst_awaddr", 64'(awaddr), 64'(0));
    chk("rst_wdata",  64'(wdata),  64'(0));
    chk("awprot",     64'(awprot), 64'(0));
    chk("wstrb",      64'(wstrb),  64'hF);
    rst = 1'b0;
    step();

    // Single write with OKAY response two cycles after issue.
    awready = 1'b1; wready = 1'b1;
    s_valid = 1'b1; s_addr = 32'h1000; s_data = 32'hDEADBEEF;
    step();
    s_valid = 1'b0;
    chk("t1_awvalid", 64'(awvalid), 64'(1));
    chk("t1_awaddr",  64'(awaddr),  64'h1000);
    step();
    chk("t1_aw_done", 64'(awvalid), 64'(0));
    chk("t1_out1",    64'(out_cnt), 64'(1));
    step();
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("t1_out0", 64'(out_cnt), 64'(0));
    chk("t1_idle", 64'(idle),    64'(1));
    chk("t1_err",  64'(err),     64'(0));

    // W held off for three cycles while AW completes immediately.
    wready = 1'b0;
    s_valid = 1'b1; s_addr = 32'h2000; s_data = 32'h5A5A5A5A;
    step();
    s_data = 32'h11111111;
    repeat (3) step();
    chk("t2_wdata",  64'(wdata),   64'h5A5A5A5A);
    chk("t2_sready", 64'(s_ready), 64'(0));
    s_valid = 1'b0; wready = 1'b1;
    step();
    drain();

    // Back-to-back writes with B withheld until the credit limit.
    n = 0;
    s_valid = 1'b1;
    repeat (6) begin
      s_addr = 32'h3000 + 32'(4 * n); s_data = 32'(n);
      step();
      if (last_acc) n++;
    end
    chk("t3_out4",   64'(out_cnt), 64'(4));
    chk("t3_stall",  64'(s_ready), 64'(0));
    bvalid = 1'b1;
    chk("t3_b_same", 64'(s_ready), 64'(0));
    step();
    bvalid = 1'b0;
    s_addr = 32'h3000 + 32'(4 * n); s_data = 32'(n);
    step();
    chk("t3_fifth",  64'(out_cnt), 64'(4));
    drain();

    // Error accounting and clear-vs-error priority.
    write_resp(32'h4000, 2'b10, 1'b0);
    write_resp(32'h4004, 2'b11, 1'b0);
    write_resp(32'h4008, 2'b00, 1'b0);
    chk("t4_err",    64'(err),     64'(1));
    chk("t4_cnt2",   64'(err_cnt), 64'(2));
    write_resp(32'h400C, 2'b10, 1'b1);
    chk("t4_clrwin", 64'(err_cnt), 64'(1));
    chk("t4_err1",   64'(err),     64'(1));

    // Saturation of the narrow counter.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int i = 0; i < 5; i++) write_resp(32'h5000 + 32'(i), 2'b10, 1'b0);
    chk("t5_sat",  64'(err_cnt2), 64'(3));
    chk("t5_wide", 64'(err_cnt),  64'(5));
    drain();

    // Random traffic with legal B behaviour.
    repeat (3000) begin
      s_valid = 1'($urandom_range(0, 1));
      s_addr  = $urandom;
      s_data  = $urandom;
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = (m_out != 0) && ($urandom_range(0, 2) != 0);
      bresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      err_clr = ($urandom_range(0, 31) == 0);
      step();
    end
    drain();

    // Asynchronous reset while AW is pending.
    awready = 1'b0; wready = 1'b1;
    s_valid = 1'b1; s_addr = 32'h6000; s_data = 32'h6;
    step();
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_awvalid", 64'(awvalid), 64'(0));
    chk("t6_out",     64'(out_cnt), 64'(0));
    chk("t6_idle",    64'(idle),    64'(1));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
